// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and the opcode legality check for alu_seq_unit.
// Honours ALU_SEQ_MUL_EN: without it, MUL is reported as an illegal opcode.
package alu_seq_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_SLTU = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_MUL  = 4'd11
   } alu_op_t;

   typedef enum logic [1:0] {IDLE, MUL_BUSY, OUT} state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
      return op <= OP_MUL;
`else
      return op <= OP_SRA;
`endif
   endfunction
endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: combinational result and carry/overflow for opcodes 0-10; anything else yields zero.
module alu_seq_comb
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v
);
   localparam int SW = $clog2(WIDTH);
   logic [WIDTH:0] sum, diff;
   logic [SW-1:0]  sh;
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign sh   = b[SW-1:0];
   always_comb begin
      result = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            c = !diff[WIDTH];
            v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: result = WIDTH'(a < b);
         OP_SLL:  result = a << sh;
         OP_SRL:  result = a >> sh;
         OP_SRA:  result = $signed(a) >>> sh;
         default: ;
      endcase
   end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshake and Z/C/V flags.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add MUL (op 11); otherwise op 11 is illegal.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IMM_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             use_imm,
   input  logic [IMM_W-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             illegal,
   output logic             busy
);
   logic [WIDTH-1:0] b_eff, alu_r, mul_r;
   logic alu_c, alu_v, accept, is_mul, mul_done;
   assign b_eff  = use_imm ? WIDTH'($signed(imm)) : src_b;
   assign accept = in_valid && in_ready;

   alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
      .op(op),
      .a(src_a),
      .b(b_eff),
      .result(alu_r),
      .c(alu_c),
      .v(alu_v)
   );

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] ma, mb, acc, acc_n;
   logic last;
   assign is_mul    = op == OP_MUL;
   assign last      = cnt == CW'(WIDTH - 1);
   assign busy      = state == MUL_BUSY;
   assign out_valid = state == OUT;
   assign in_ready  = !busy && (!out_valid || out_ready);
   assign acc_n     = acc + (mb[cnt] ? ma << cnt : '0);
   assign mul_done  = busy && last;
   assign mul_r     = acc_n;
   always_comb begin
      state_n = busy ? (last ? OUT : MUL_BUSY)
              : accept ? (is_mul ? MUL_BUSY : OUT)
              : (out_valid && !out_ready) ? OUT : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         ma    <= '0;
         mb    <= '0;
      end else begin
         state <= state_n;
         if (accept && is_mul) begin
            ma  <= src_a;
            mb  <= b_eff;
            cnt <= '0;
            acc <= '0;
         end else if (busy) begin
            acc <= acc_n;
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   logic held;
   assign is_mul    = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_r     = '0;
   assign busy      = 1'b0;
   assign out_valid = held;
   assign in_ready  = !held || out_ready;
   always_ff @(posedge clk) begin
      if (rst) held <= 1'b0;
      else if (accept) held <= 1'b1;
      else if (out_ready) held <= 1'b0;
   end
`endif

   // Output register only moves on a completed MUL or an accepted single-cycle op.
   always_ff @(posedge clk) begin
      if (rst) begin
         result  <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         illegal <= 1'b0;
      end else if (mul_done) begin
         result  <= mul_r;
         flag_z  <= mul_r == '0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         illegal <= 1'b0;
      end else if (accept && !is_mul) begin
         result  <= alu_r;
         flag_z  <= alu_r == '0;
         flag_c  <= alu_c;
         flag_v  <= alu_v;
         illegal <= !is_legal_op(op);
      end
   end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors for alu_seq_unit, scoreboard queue checked by a negedge monitor.
// Follows ALU_SEQ_MUL_EN to pick the MUL expectations.
module tb_alu_seq_unit;
   import alu_seq_pkg::*;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, use_imm = 1'b0, out_ready = 1'b1;
   logic [3:0] op = '0;
   logic [15:0] src_a = '0, src_b = '0;
   logic [6:0] imm = '0;
   logic in_ready, out_valid, flag_z, flag_c, flag_v, illegal, busy;
   logic [15:0] result;
   typedef struct {
      string       name;
      logic [19:0] v;
   } exp_t;
   exp_t sb[$];
   int checks = 0, fails = 0;

   always #5 clk = ~clk;

   alu_seq_unit #(.WIDTH(16), .IMM_W(7)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .src_a(src_a), .src_b(src_b), .use_imm(use_imm), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal), .busy(busy)
   );

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] pk(input logic [15:0] r, input logic z, c, v, il);
      return {r, z, c, v, il};
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output: got %h expected none", pk(result, flag_z, flag_c, flag_v, illegal));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, pk(result, flag_z, flag_c, flag_v, illegal), e.v);
         end
      end
   end

   task automatic issue(input string name, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic ui, input logic [6:0] im, input logic [19:0] e);
      int n = 0;
      op = o; src_a = a; src_b = b; use_imm = ui; imm = im; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check({name, "_accept"}, {19'b0, in_ready}, 20'd1);
      if (in_ready) sb.push_back('{name, e});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("drain", 20'(sb.size()), 20'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_state", {result, out_valid, busy, illegal, in_ready}, {16'h0, 4'b0001});
      check("reset_flags", {17'b0, flag_z, flag_c, flag_v}, 20'd0);
      @(posedge clk);
      #1;
      issue("add_small", OP_ADD, 16'h0001, 16'h0003, 1'b0, 7'h00, pk(16'h0004, 0, 0, 0, 0));
      issue("add_carry", OP_ADD, 16'hFFFF, 16'hFFF0, 1'b0, 7'h00, pk(16'hFFEF, 0, 1, 0, 0));
      issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 7'h00, pk(16'h8000, 0, 0, 1, 0));
      issue("sub_zero", OP_SUB, 16'h0005, 16'h0005, 1'b0, 7'h00, pk(16'h0000, 1, 1, 0, 0));
      issue("add_imm", OP_ADD, 16'h0001, 16'h1234, 1'b1, 7'h7E, pk(16'hFFFF, 0, 0, 0, 0));
      issue("and_imm", OP_AND, 16'h00FF, 16'h1234, 1'b1, 7'h7E, pk(16'h00FE, 0, 0, 0, 0));
      issue("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 1'b0, 7'h00, pk(16'hFFFE, 0, 0, 0, 0));
      issue("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, 7'h00, pk(16'h7FFF, 0, 1, 1, 0));
      issue("slt", OP_SLT, 16'hFFFF, 16'h0001, 1'b0, 7'h00, pk(16'h0001, 0, 0, 0, 0));
      issue("sltu", OP_SLTU, 16'hFFFF, 16'h0001, 1'b0, 7'h00, pk(16'h0000, 1, 0, 0, 0));
      issue("sll_mask", OP_SLL, 16'h0001, 16'h0014, 1'b0, 7'h00, pk(16'h0010, 0, 0, 0, 0));
      issue("srl", OP_SRL, 16'h8000, 16'h0003, 1'b0, 7'h00, pk(16'h1000, 0, 0, 0, 0));
      issue("sra", OP_SRA, 16'h8000, 16'h0003, 1'b0, 7'h00, pk(16'hF000, 0, 0, 0, 0));
      issue("sra_max", OP_SRA, 16'h8000, 16'h000F, 1'b0, 7'h00, pk(16'hFFFF, 0, 0, 0, 0));
      issue("xor", OP_XOR, 16'hAAAA, 16'hFFFF, 1'b0, 7'h00, pk(16'h5555, 0, 0, 0, 0));
      issue("nor", OP_NOR, 16'h0000, 16'h0000, 1'b0, 7'h00, pk(16'hFFFF, 0, 0, 0, 0));
      issue("or", OP_OR, 16'h0F00, 16'h00F0, 1'b0, 7'h00, pk(16'h0FF0, 0, 0, 0, 0));
      issue("illegal_12", 4'd12, 16'h1234, 16'h5678, 1'b0, 7'h00, pk(16'h0000, 1, 0, 0, 1));
      drain();
`ifdef ALU_SEQ_MUL_EN
      issue("mul", OP_MUL, 16'h0003, 16'h0005, 1'b0, 7'h00, pk(16'h000F, 0, 0, 0, 0));
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ok &= busy && !in_ready && !out_valid;
      end
      check("mul_busy_window", {19'b0, ok}, 20'd1);
      @(negedge clk);
      check("mul_latency", {18'b0, out_valid, busy}, 20'b10);
      issue("mul_wrap", OP_MUL, 16'h0100, 16'h0100, 1'b0, 7'h00, pk(16'h0000, 1, 0, 0, 0));
`else
      issue("mul_illegal", OP_MUL, 16'h0003, 16'h0005, 1'b0, 7'h00, pk(16'h0000, 1, 0, 0, 1));
`endif
      drain();
      out_ready = 1'b0;
      issue("bp_add", OP_ADD, 16'h0010, 16'h0020, 1'b0, 7'h00, pk(16'h0030, 0, 0, 0, 0));
      op = OP_AND; src_a = 16'hF0F0; src_b = 16'h0FF0; use_imm = 1'b0; in_valid = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ok &= out_valid && !in_ready && result == 16'h0030;
      end
      check("bp_hold", {19'b0, ok}, 20'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", {19'b0, in_ready}, 20'd1);
      sb.push_back('{"bp_and", pk(16'h00F0, 0, 0, 0, 0)});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_no_bubble", {19'b0, out_valid}, 20'd1);
      drain();
`ifdef ALU_SEQ_MUL_EN
      issue("mul_abort", OP_MUL, 16'h0003, 16'h0005, 1'b0, 7'h00, pk(16'h000F, 0, 0, 0, 0));
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      check("busy_before_rst", {19'b0, busy}, 20'd1);
`else
      out_ready = 1'b0;
      issue("held_abort", OP_ADD, 16'h0001, 16'h0001, 1'b0, 7'h00, pk(16'h0002, 0, 0, 0, 0));
      #1 rst = 1'b1;
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      check("rst_abort", {17'b0, out_valid, busy, in_ready}, 20'd1);
      @(posedge clk);
      #1;
      issue("illegal_13", 4'd13, 16'hFFFF, 16'hFFFF, 1'b0, 7'h00, pk(16'h0000, 1, 0, 0, 1));
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
